// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side computes them.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, overflow, zero
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// one result bit per clock, LSB first, with carry/overflow/zero flags.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;

    logic             a_bit;
    logic             b_bit;
    logic             sum;
    logic             c_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            IDLE:    accept = bus.start;
            CALC:    if (cnt == LAST) state_n = DONE;
            DONE: begin
                state_n = IDLE;
                accept  = bus.start;
            end
            default: state_n = IDLE;
        endcase
        if (accept) state_n = CALC;
    end

    always_comb begin
        a_bit   = a_q[cnt];
        b_bit   = b_q[cnt];
        sum     = a_bit ^ b_bit ^ c;
        c_nxt   = (a_bit & b_bit) | (a_bit & c) | (b_bit & c);
        res_nxt = {sum, result_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            c          <= 1'b0;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                // b is pre-inverted and carry seeded with op: a + ~b + 1
                a_q  <= bus.a;
                b_q  <= bus.op ? ~bus.b : bus.b;
                op_q <= bus.op;
                c    <= bus.op;
                cnt  <= '0;
            end else if (state == CALC) begin
                result_q <= res_nxt;
                c        <= c_nxt;
                cnt      <= cnt + 1'b1;
                if (cnt == LAST) begin
                    carry_q    <= op_q ? ~c_nxt : c_nxt;
                    overflow_q <= c ^ c_nxt;
                    zero_q     <= (res_nxt == '0);
                end
            end
        end
    end

    assign bus.busy     = (state == CALC);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8 and WIDTH=4.
// Expected values come from an integer-arithmetic reference model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) if8 ();
    serial_addsub_if #(.WIDTH(4)) if4 ();

    serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst8), .bus(if8));
    serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4));

    function automatic void ref_model(input int w, input int a, input int b,
                                      input bit op, output int r, output bit c,
                                      output bit v, output bit z);
        int mask, hi, lo, sa, sb, ideal;
        mask = (1 << w) - 1;
        hi   = (1 << (w - 1)) - 1;
        lo   = -(1 << (w - 1));
        if (!op) begin
            r = (a + b) & mask;
            c = (a + b) > mask;
        end else begin
            r = (a - b) & mask;
            c = a < b;
        end
        sa    = (a > hi) ? a - (1 << w) : a;
        sb    = (b > hi) ? b - (1 << w) : b;
        ideal = op ? sa - sb : sa + sb;
        v     = (ideal > hi) || (ideal < lo);
        z     = (r == 0);
    endfunction

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input bit op, input bit noisy);
        int r;
        bit c, v, z;
        logic [10:0] got, exp;
        ref_model(8, int'(a), int'(b), op, r, c, v, z);
        exp = {r[7:0], c, v, z};
        if8.start = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.op = op;
        @(negedge clk);
        if8.start = noisy;
        for (int k = 0; k < 8; k++) begin
            if (noisy) begin
                if8.a  = 8'hAA;
                if8.b  = 8'($urandom);
                if8.op = ~if8.op;
            end
            checks++;
            if ({if8.busy, if8.done} !== 2'b10) begin
                errors++;
                $display("FAIL busy8 cyc=%0d got busy=%b done=%b want 1 0",
                         k, if8.busy, if8.done);
            end
            @(negedge clk);
        end
        if8.start = 1'b0;
        checks++;
        if ({if8.busy, if8.done} !== 2'b01) begin
            errors++;
            $display("FAIL done8 got busy=%b done=%b want 0 1",
                     if8.busy, if8.done);
        end
        got = {if8.result, if8.carry, if8.overflow, if8.zero};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL res8 a=%h b=%h op=%0d got %h/%b%b%b want %h/%b%b%b",
                     a, b, op, got[10:3], got[2], got[1], got[0],
                     exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic idle8();
        @(negedge clk);
        checks++;
        if ({if8.busy, if8.done} !== 2'b00) begin
            errors++;
            $display("FAIL idle8 got busy=%b done=%b want 0 0",
                     if8.busy, if8.done);
        end
    endtask

    task automatic issue4(input int a, input int b, input bit op);
        int r;
        bit c, v, z;
        logic [6:0] got, exp;
        ref_model(4, a, b, op, r, c, v, z);
        exp = {r[3:0], c, v, z};
        if4.start = 1'b1;
        if4.a = 4'(a);
        if4.b = 4'(b);
        if4.op = op;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (4) @(negedge clk);
        got = {if4.result, if4.carry, if4.overflow, if4.zero};
        checks++;
        if (if4.done !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL res4 a=%0d b=%0d op=%0d done=%b got %h want %h",
                     a, b, op, if4.done, got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst8 = 1'b1;
        rst4 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({if8.busy, if8.done, if8.result, if8.carry, if8.overflow,
             if8.zero} !== 13'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b res=%h flags=%b%b%b want 0",
                     if8.busy, if8.done, if8.result, if8.carry, if8.overflow,
                     if8.zero);
        end
        checks++;
        if ({if4.busy, if4.done, if4.result, if4.carry, if4.overflow,
             if4.zero} !== 9'd0) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b res=%h want 0",
                     if4.busy, if4.done, if4.result);
        end
        rst8 = 1'b0;
        rst4 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         op;
        logic [7:0] r;
        bit         c;
        bit         v;
        bit         z;
    } vec_t;

    task automatic test_directed();
        vec_t t[5];
        t[0] = '{8'h2D, 8'h1C, 1'b0, 8'h49, 1'b0, 1'b0, 1'b0};
        t[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        t[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        t[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
        t[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            issue8(t[i].a, t[i].b, t[i].op, 1'b0);
            checks++;
            if ({if8.result, if8.carry, if8.overflow, if8.zero} !==
                {t[i].r, t[i].c, t[i].v, t[i].z}) begin
                errors++;
                $display("FAIL directed%0d got %h c=%b v=%b z=%b want %h c=%b v=%b z=%b",
                         i, if8.result, if8.carry, if8.overflow, if8.zero,
                         t[i].r, t[i].c, t[i].v, t[i].z);
            end
            idle8();
        end
    endtask

    task automatic test_ignore_start();
        issue8(8'h2D, 8'h1C, 1'b0, 1'b1);
        checks++;
        if (if8.result !== 8'h49) begin
            errors++;
            $display("FAIL ignore_start got %h want 49", if8.result);
        end
        idle8();
    endtask

    task automatic test_back_to_back();
        issue8(8'h12, 8'h34, 1'b1, 1'b0);
        issue8(8'hC8, 8'h64, 1'b0, 1'b0);
        issue8(8'h00, 8'h00, 1'b1, 1'b0);
        idle8();
    endtask

    task automatic test_reset_mid();
        if8.start = 1'b1;
        if8.a = 8'hFF;
        if8.b = 8'h00;
        if8.op = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        checks++;
        if ({if8.busy, if8.done, if8.result, if8.carry, if8.overflow,
             if8.zero} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b res=%h flags=%b%b%b want 0",
                     if8.busy, if8.done, if8.result, if8.carry, if8.overflow,
                     if8.zero);
        end
        rst8 = 1'b0;
        issue8(8'h3C, 8'h3C, 1'b1, 1'b0);
        idle8();
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(1, 0) == 0) idle8();
        end
        idle8();
    endtask

    task automatic test_width4();
        for (int op = 0; op < 2; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    issue4(a, b, 1'(op));
    endtask

    initial begin
        if8.start = 1'b0;
        if8.op = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if4.start = 1'b0;
        if4.op = 1'b0;
        if4.a = '0;
        if4.b = '0;
        rst8 = 1'b1;
        rst4 = 1'b1;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
